// File: rtl/seg14_drive.sv
// rtl/seg14_drive.sv - blanking, PWM and select-checking output driver for a 12-digit 14-segment display
//
// Sits after the digit scanner and drives the display pins. Each digit change
// is preceded by BLANK_CYC dark cycles. Segments are gated by a 16-step PWM.
// Selects with two or more bits set are rejected, and a one-cycle frame marker
// is raised when digit 0 lights.
//
// Optional feature macro: SEG14_STALL_GUARD_EN
//   When defined, a digit held ON for STALL_LIMIT cycles is forced dark and
//   `stall` is raised. When undefined, `stall` is tied low and no counter exists.
//
// Parameters:
//   BLANK_CYC   - dark cycles per digit change (1..15)
//   STALL_LIMIT - ON cycles before the stall guard trips
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   en         - driver enable, 0 forces dark and forgets the current digit
//   sel_in     - one-hot or zero digit select from the scanner
//   segm_in    - active-high segment pattern from the scanner
//   bright     - PWM duty in sixteenths
//   sel_out    - registered digit drive
//   segm_out   - registered segment drive
//   frame_tick - one-cycle pulse in the first ON cycle of digit 0
//   fault      - sticky, an illegal select was seen
//   stall      - stall guard tripped

module seg14_drive #(
    parameter int BLANK_CYC   = 2,
    parameter int STALL_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] sel_in,
    input  logic [13:0] segm_in,
    input  logic [3:0]  bright,
    output logic [11:0] sel_out,
    output logic [13:0] segm_out,
    output logic        frame_tick,
    output logic        fault,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYC - 1);

    state_t      state, state_n;
    logic [11:0] cur_sel, cur_sel_n;
    logic [11:0] pend_sel, pend_sel_n;
    logic [13:0] seg_q, seg_q_n;
    logic [3:0]  pwm_cnt, pwm_cnt_n;
    logic [3:0]  blank_cnt, blank_cnt_n;
    logic [11:0] sel_out_n;
    logic [13:0] segm_out_n;
    logic        frame_tick_n;
    logic        fault_n;

`ifdef SEG14_STALL_GUARD_EN
    localparam int SCW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_LIMIT - 1);

    logic [SCW-1:0] stall_cnt, stall_cnt_n;
    logic           stall_r, stall_n;

    assign stall = stall_r;
`else
    logic unused_stall_limit;

    assign unused_stall_limit = |32'(STALL_LIMIT);
    assign stall              = 1'b0;
`endif

    // Classify the select: zero, exactly one bit (valid), or more (illegal).
    logic sel_zero;
    logic sel_valid;
    logic sel_illegal;

    assign sel_zero    = (sel_in == 12'h000);
    assign sel_valid   = !sel_zero && ((sel_in & (sel_in - 12'd1)) == 12'h000);
    assign sel_illegal = !sel_zero && !sel_valid;

    always_comb begin
        state_n      = state;
        cur_sel_n    = cur_sel;
        pend_sel_n   = pend_sel;
        seg_q_n      = seg_q;
        pwm_cnt_n    = pwm_cnt;
        blank_cnt_n  = blank_cnt;
        fault_n      = fault;
        sel_out_n    = 12'h000;
        segm_out_n   = 14'h0000;
        frame_tick_n = 1'b0;
`ifdef SEG14_STALL_GUARD_EN
        stall_cnt_n  = stall_cnt;
        stall_n      = stall_r;
`endif

        if (!en) begin
            // Forgetting cur_sel makes the same digit relight through BLANK.
            state_n   = IDLE;
            cur_sel_n = 12'h000;
        end else if (sel_illegal) begin
            fault_n = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid && (sel_in != cur_sel)) begin
                        state_n     = BLANK;
                        pend_sel_n  = sel_in;
                        blank_cnt_n = BLANK_LOAD;
`ifdef SEG14_STALL_GUARD_EN
                        stall_n     = 1'b0;
`endif
                    end
                end

                BLANK: begin
                    if (sel_zero) begin
                        state_n = IDLE;
                    end else if (sel_in != pend_sel) begin
                        // Scanner moved on before the gap finished: restart it.
                        pend_sel_n  = sel_in;
                        blank_cnt_n = BLANK_LOAD;
                    end else if (blank_cnt == 4'd0) begin
                        // Go live: the first ON cycle uses PWM count 0.
                        state_n      = ON;
                        cur_sel_n    = pend_sel;
                        seg_q_n      = segm_in;
                        pwm_cnt_n    = 4'd0;
                        sel_out_n    = pend_sel;
                        segm_out_n   = (bright != 4'd0) ? segm_in : 14'h0000;
                        frame_tick_n = (pend_sel == 12'h001);
`ifdef SEG14_STALL_GUARD_EN
                        stall_cnt_n  = '0;
`endif
                    end else begin
                        blank_cnt_n = blank_cnt - 4'd1;
                    end
                end

                ON: begin
                    if (sel_zero) begin
                        state_n = IDLE;
`ifdef SEG14_STALL_GUARD_EN
                    end else if (stall_cnt == STALL_LAST) begin
                        state_n = IDLE;
                        stall_n = 1'b1;
`endif
                    end else if (sel_in != cur_sel) begin
                        state_n     = BLANK;
                        pend_sel_n  = sel_in;
                        blank_cnt_n = BLANK_LOAD;
`ifdef SEG14_STALL_GUARD_EN
                        stall_n     = 1'b0;
`endif
                    end else begin
                        pwm_cnt_n  = pwm_cnt + 4'd1;
                        sel_out_n  = cur_sel;
                        segm_out_n = (pwm_cnt_n < bright) ? seg_q : 14'h0000;
`ifdef SEG14_STALL_GUARD_EN
                        stall_cnt_n = stall_cnt + 1'b1;
`endif
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_sel    <= 12'h000;
            pend_sel   <= 12'h000;
            seg_q      <= 14'h0000;
            pwm_cnt    <= 4'd0;
            blank_cnt  <= 4'd0;
            sel_out    <= 12'h000;
            segm_out   <= 14'h0000;
            frame_tick <= 1'b0;
            fault      <= 1'b0;
`ifdef SEG14_STALL_GUARD_EN
            stall_cnt  <= '0;
            stall_r    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cur_sel    <= cur_sel_n;
            pend_sel   <= pend_sel_n;
            seg_q      <= seg_q_n;
            pwm_cnt    <= pwm_cnt_n;
            blank_cnt  <= blank_cnt_n;
            sel_out    <= sel_out_n;
            segm_out   <= segm_out_n;
            frame_tick <= frame_tick_n;
            fault      <= fault_n;
`ifdef SEG14_STALL_GUARD_EN
            stall_cnt  <= stall_cnt_n;
            stall_r    <= stall_n;
`endif
        end
    end

endmodule

// File: tb/tb_seg14_drive.sv
// tb/tb_seg14_drive.sv - directed self-checking bench for seg14_drive

module tb_seg14_drive;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [11:0] sel_in;
    logic [13:0] segm_in;
    logic [3:0]  bright;

    logic [11:0] sel_a, sel_b, sel_c;
    logic [13:0] segm_a, segm_b, segm_c;
    logic        tick_a, tick_b, tick_c;
    logic        fault_a, fault_b, fault_c;
    logic        stall_a, stall_b, stall_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg14_drive #(.BLANK_CYC(2), .STALL_LIMIT(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_in(sel_in), .segm_in(segm_in),
        .bright(bright), .sel_out(sel_a), .segm_out(segm_a), .frame_tick(tick_a),
        .fault(fault_a), .stall(stall_a)
    );

    seg14_drive #(.BLANK_CYC(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_in(sel_in), .segm_in(segm_in),
        .bright(bright), .sel_out(sel_b), .segm_out(segm_b), .frame_tick(tick_b),
        .fault(fault_b), .stall(stall_b)
    );

    seg14_drive #(.BLANK_CYC(3)) u_dut_b3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_in(sel_in), .segm_in(segm_in),
        .bright(bright), .sel_out(sel_c), .segm_out(segm_c), .frame_tick(tick_c),
        .fault(fault_c), .stall(stall_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] exp_sel;
    logic [13:0] exp_seg;
    logic [15:0] on_mask;
    int          lit_cnt;

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        sel_in  = 12'h000;
        segm_in = 14'h0000;
        bright  = 4'd15;
        step();
        step();
        check("rst_sel", 32'(sel_a), 32'h0);
        check("rst_segm", 32'(segm_a), 32'h0);
        check("rst_tick", 32'(tick_a), 32'h0);
        check("rst_fault", 32'(fault_a), 32'h0);
        check("rst_stall", 32'(stall_a), 32'h0);

        // Basic: two dark cycles, then 15/16 duty with one frame tick.
        rst_n   = 1'b1;
        en      = 1'b1;
        sel_in  = 12'h001;
        segm_in = 14'h3BC0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("basic_sel", 32'(sel_a), (k >= 2) ? 32'h001 : 32'h0);
            check("basic_segm", 32'(segm_a),
                  (k >= 2 && ((k - 2) % 16) != 15) ? 32'h3BC0 : 32'h0);
            check("basic_tick", 32'(tick_a), (k == 2) ? 32'h1 : 32'h0);
        end

        // Blank gap on a digit change.
        sel_in  = 12'h002;
        segm_in = 14'h2780;
        step();
        check("gap_dark0", 32'(sel_a), 32'h0);
        step();
        check("gap_dark1", 32'(sel_a), 32'h0);
        check("gap_dark1_segm", 32'(segm_a), 32'h0);
        step();
        check("gap_sel", 32'(sel_a), 32'h002);
        check("gap_segm", 32'(segm_a), 32'h2780);
        check("gap_tick", 32'(tick_a), 32'h0);

        // Sweep 12 digits; each instance has its own gap length.
        for (int d = 0; d < 12; d++) begin
            exp_sel = 12'h001 << d;
            exp_seg = 14'h2000 | (14'h0001 << d);
            sel_in  = exp_sel;
            segm_in = exp_seg;
            for (int j = 1; j <= 6; j++) begin
                step();
                check("sw_b2_sel", 32'(sel_a), (j > 2) ? 32'(exp_sel) : 32'h0);
                check("sw_b2_segm", 32'(segm_a), (j > 2) ? 32'(exp_seg) : 32'h0);
                check("sw_b2_tick", 32'(tick_a), (j == 3 && d == 0) ? 32'h1 : 32'h0);
                check("sw_b1_sel", 32'(sel_b), (j > 1) ? 32'(exp_sel) : 32'h0);
                check("sw_b1_segm", 32'(segm_b), (j > 1) ? 32'(exp_seg) : 32'h0);
                check("sw_b3_sel", 32'(sel_c), (j > 3) ? 32'(exp_sel) : 32'h0);
                check("sw_b3_segm", 32'(segm_c), (j > 3) ? 32'(exp_seg) : 32'h0);
            end
        end

        // Brightness 0: select driven, segments dark.
        bright  = 4'd0;
        sel_in  = 12'h004;
        segm_in = 14'h3FFF;
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check("br0_sel", 32'(sel_a), 32'h004);
            check("br0_segm", 32'(segm_a), 32'h0);
        end

        // Brightness 4: on for the first 4 of 16 cycles from ON entry.
        bright  = 4'd4;
        sel_in  = 12'h008;
        segm_in = 14'h1555;
        step();
        step();
        on_mask = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            step();
            on_mask[i] = (segm_a == 14'h1555);
            check("br4_sel", 32'(sel_a), 32'h008);
        end
        check("br4_mask", 32'(on_mask), 32'h000F);

        // Illegal select: fault and dark on the next edge, then relight.
        bright = 4'd15;
        sel_in = 12'h003;
        step();
        check("ill_fault", 32'(fault_a), 32'h1);
        check("ill_sel", 32'(sel_a), 32'h0);
        check("ill_segm", 32'(segm_a), 32'h0);
        sel_in  = 12'h004;
        segm_in = 14'h0F0F;
        step();
        check("ill_dark0", 32'(sel_a), 32'h0);
        step();
        check("ill_dark1", 32'(sel_a), 32'h0);
        step();
        check("ill_relit_sel", 32'(sel_a), 32'h004);
        check("ill_relit_segm", 32'(segm_a), 32'h0F0F);
        check("ill_sticky", 32'(fault_a), 32'h1);

        // Enable drop and re-raise with the same select.
        en = 1'b0;
        step();
        check("en_off_sel", 32'(sel_a), 32'h0);
        check("en_off_segm", 32'(segm_a), 32'h0);
        step();
        en = 1'b1;
        step();
        check("en_on_dark0", 32'(sel_a), 32'h0);
        step();
        check("en_on_dark1", 32'(sel_a), 32'h0);
        step();
        check("en_on_sel", 32'(sel_a), 32'h004);
        check("en_on_segm", 32'(segm_a), 32'h0F0F);

        // Reset in the middle of BLANK.
        sel_in  = 12'h020;
        segm_in = 14'h0AAA;
        step();
        rst_n = 1'b0;
        step();
        check("rstb_sel", 32'(sel_a), 32'h0);
        check("rstb_segm", 32'(segm_a), 32'h0);
        check("rstb_fault", 32'(fault_a), 32'h0);
        check("rstb_tick", 32'(tick_a), 32'h0);
        rst_n = 1'b1;
        step();
        check("rstb_dark0", 32'(sel_a), 32'h0);
        step();
        check("rstb_dark1", 32'(sel_a), 32'h0);
        step();
        check("rstb_sel_lit", 32'(sel_a), 32'h020);
        check("rstb_segm_lit", 32'(segm_a), 32'h0AAA);

        // Zero select keeps cur_sel: the same digit does not relight.
        sel_in = 12'h000;
        step();
        check("zero_dark", 32'(sel_a), 32'h0);
        sel_in = 12'h020;
        for (int i = 0; i < 4; i++) begin
            step();
            check("zero_same_dark", 32'(sel_a), 32'h0);
        end
        check("zero_nofault", 32'(fault_a), 32'h0);
        sel_in  = 12'h040;
        segm_in = 14'h0123;
        step();
        step();
        step();
        check("zero_new_sel", 32'(sel_a), 32'h040);
        check("zero_new_segm", 32'(segm_a), 32'h0123);

        // Stall guard.
        sel_in  = 12'h010;
        segm_in = 14'h0321;
        step();
        step();
`ifdef SEG14_STALL_GUARD_EN
        lit_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sel_a == 12'h010) lit_cnt++;
        end
        check("stall_lit_cycles", 32'(lit_cnt), 32'd32);
        check("stall_flag", 32'(stall_a), 32'h1);
        check("stall_dark", 32'(sel_a), 32'h0);
        sel_in = 12'h020;
        step();
        check("stall_clear", 32'(stall_a), 32'h0);
`else
        lit_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sel_a == 12'h010) lit_cnt++;
        end
        check("nostall_lit_cycles", 32'(lit_cnt), 32'd100);
        check("nostall_flag", 32'(stall_a), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
